// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/WAIT/HOLD/RESOLVE sequencer with branch-resolved pc update.
// Optional link register and taken-branch counter when FETCH_LINK_REG_EN is defined.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        branchResolve,
  input  logic        unconditionalBranch,
  input  logic        branch,
  input  logic        zeroFlag,
  input  logic [63:0] branchOffset,
  output logic [63:0] pc
`ifdef FETCH_LINK_REG_EN
  ,
  output logic [63:0] linkAddr,
  output logic [31:0] takenCount
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, RESOLVE} state_t;

  state_t      state;
  logic        taken;
  logic [63:0] next_pc;

  always_comb begin
    taken   = unconditionalBranch | (branch & zeroFlag);
    next_pc = taken ? pc + (branchOffset << 2) : pc + 64'd4;
  end

  assign imemAddr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imemReq     <= 1'b0;
      instrValid  <= 1'b0;
      instruction <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imemAck) begin
            instruction <= imemData;
            instrValid  <= 1'b1;
            imemReq     <= 1'b0;
            state       <= HOLD;
          end else begin
            imemReq <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (imemAck) begin
            instruction <= imemData;
            instrValid  <= 1'b1;
            imemReq     <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instrValid && instrReady) begin
            instrValid <= 1'b0;
            state      <= RESOLVE;
          end
        end
        RESOLVE: begin
          // Raising imemReq here gives a request one cycle after the resolve edge.
          if (branchResolve) begin
            pc      <= next_pc;
            imemReq <= 1'b1;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_LINK_REG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      linkAddr   <= '0;
      takenCount <= '0;
    end else if (state == RESOLVE && branchResolve) begin
      if (unconditionalBranch) linkAddr <= pc + 64'd4;
      if (taken) takenCount <= takenCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cache model queues each acked word, the
// decoder side pops and compares on acceptance, and a pc model checks every resolve.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clock;
  logic        reset;
  logic [63:0] imemAddr;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic        instrValid;
  logic        instrReady;
  logic        branchResolve;
  logic        unconditionalBranch;
  logic        branch;
  logic        zeroFlag;
  logic [63:0] branchOffset;
  logic [63:0] pc;
`ifdef FETCH_LINK_REG_EN
  logic [63:0] linkAddr;
  logic [31:0] takenCount;
  logic [63:0] exp_link;
  logic [31:0] exp_count;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock(clock),
    .reset(reset),
    .imemAddr(imemAddr),
    .imemReq(imemReq),
    .imemAck(imemAck),
    .imemData(imemData),
    .instruction(instruction),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .branchResolve(branchResolve),
    .unconditionalBranch(unconditionalBranch),
    .branch(branch),
    .zeroFlag(zeroFlag),
    .branchOffset(branchOffset),
    .pc(pc)
`ifdef FETCH_LINK_REG_EN
    ,
    .linkAddr(linkAddr),
    .takenCount(takenCount)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_pc;
  int          lat = 2;
  logic        cache_en = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return (addr == 64'h0) ? 32'h8B020020 : (addr[31:0] ^ 32'h5EED_0001);
  endfunction

  function automatic logic [63:0] off_to(input logic [63:0] tgt);
    logic signed [63:0] d;
    d = $signed(tgt - exp_pc);
    return d >>> 2;
  endfunction

  // Cache model: acks one cycle after 'lat' cycles of request, queues the word.
  initial begin
    int cnt;
    cnt = 0;
    imemAck = 1'b0;
    imemData = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset || !cache_en) begin
        cnt = 0;
        if (cache_en) imemAck = 1'b0;
      end else if (imemAck) begin
        imemAck = 1'b0;
      end else if (imemReq) begin
        if (cnt >= lat) begin
          imemAck  = 1'b1;
          imemData = mem_word(imemAddr);
          exp_q.push_back(imemData);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic do_instr(input int hold, input logic ub, input logic br,
                          input logic zf, input logic [63:0] off);
    int n;
    logic [31:0] snap;
    logic [31:0] want;
    logic tk;
    n = 0;
    while (!instrValid && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("valid_wait", {63'd0, instrValid}, 64'd1);
    snap = instruction;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        branchResolve = 1'b1;
        unconditionalBranch = 1'b1;
        branchOffset = 64'd5;
      end
      @(negedge clock);
      branchResolve = 1'b0;
      unconditionalBranch = 1'b0;
      branchOffset = '0;
      check("hold_instr", {32'd0, instruction}, {32'd0, snap});
      check("hold_valid", {63'd0, instrValid}, 64'd1);
      check("hold_req", {63'd0, imemReq}, 64'd0);
      check("hold_pc", pc, exp_pc);
    end
    if (exp_q.size() == 0) begin
      check("q_empty", 64'd1, {63'd0, instrValid});
      want = '0;
    end else begin
      want = exp_q.pop_front();
    end
    check("instr", {32'd0, instruction}, {32'd0, want});
    check("addr", imemAddr, exp_pc);
    instrReady = 1'b1;
    @(negedge clock);
    instrReady = 1'b0;
    check("valid_clr", {63'd0, instrValid}, 64'd0);
    @(negedge clock);
    check("resolve_pc_hold", pc, exp_pc);
    check("resolve_req", {63'd0, imemReq}, 64'd0);
    unconditionalBranch = ub;
    branch = br;
    zeroFlag = zf;
    branchOffset = off;
    branchResolve = 1'b1;
    @(negedge clock);
    branchResolve = 1'b0;
    unconditionalBranch = 1'b0;
    branch = 1'b0;
    zeroFlag = 1'b0;
    branchOffset = '0;
    tk = ub | (br & zf);
`ifdef FETCH_LINK_REG_EN
    if (ub) exp_link = exp_pc + 64'd4;
    if (tk) exp_count = exp_count + 32'd1;
`endif
    exp_pc = tk ? exp_pc + (off << 2) : exp_pc + 64'd4;
    check("pc", pc, exp_pc);
    check("req_after", {63'd0, imemReq}, 64'd1);
`ifdef FETCH_LINK_REG_EN
    check("link", linkAddr, exp_link);
    check("count", {32'd0, takenCount}, {32'd0, exp_count});
`endif
  endtask

  initial begin
    reset = 1'b1;
    instrReady = 1'b0;
    branchResolve = 1'b0;
    unconditionalBranch = 1'b0;
    branch = 1'b0;
    zeroFlag = 1'b0;
    branchOffset = '0;
    exp_pc = RST_PC;
`ifdef FETCH_LINK_REG_EN
    exp_link = '0;
    exp_count = '0;
`endif
    repeat (2) @(negedge clock);
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imemAddr, RST_PC);
    check("rst_req", {63'd0, imemReq}, 64'd0);
    check("rst_valid", {63'd0, instrValid}, 64'd0);
    check("rst_instr", {32'd0, instruction}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("first_req", {63'd0, imemReq}, 64'd1);

    do_instr(0, 1'b0, 1'b0, 1'b0, 64'd7);
    do_instr(0, 1'b1, 1'b0, 1'b0, off_to(64'h100));
    do_instr(0, 1'b1, 1'b0, 1'b0, -64'sd4);
    do_instr(0, 1'b0, 1'b1, 1'b0, 64'd7);
    do_instr(0, 1'b0, 1'b1, 1'b1, 64'd3);
    lat = 0;
    do_instr(5, 1'b0, 1'b0, 1'b0, 64'd0);
    lat = 1;
    do_instr(0, 1'b1, 1'b0, 1'b0, off_to(64'hFFFF_FFFF_FFFF_FFFC));
    do_instr(2, 1'b0, 1'b1, 1'b0, 64'd9);
    do_instr(0, 1'b1, 1'b0, 1'b0, -64'sd1);
    do_instr(0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Reset while WAIT is outstanding, with a stray ack during reset.
    cache_en = 1'b0;
    lat = 2;
    @(negedge clock);
    check("wait_req", {63'd0, imemReq}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_req", {63'd0, imemReq}, 64'd0);
    check("mid_rst_valid", {63'd0, instrValid}, 64'd0);
    imemAck = 1'b1;
    imemData = 32'hDEAD_BEEF;
    repeat (2) @(negedge clock);
    check("late_ack_valid", {63'd0, instrValid}, 64'd0);
    check("late_ack_instr", {32'd0, instruction}, 64'd0);
    imemAck = 1'b0;
    exp_q.delete();
    exp_pc = RST_PC;
`ifdef FETCH_LINK_REG_EN
    exp_link = '0;
    exp_count = '0;
    check("rst_link", linkAddr, 64'd0);
    check("rst_count", {32'd0, takenCount}, 64'd0);
`endif
    cache_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("fresh_req", {63'd0, imemReq}, 64'd1);
    check("fresh_pc", pc, RST_PC);
    check("fresh_valid", {63'd0, instrValid}, 64'd0);
    do_instr(1, 1'b0, 1'b1, 1'b1, -64'sd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, the byte address fetched first after reset.
REQ-002 The block SHALL have port clock, input, 1, the main clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port imemAddr, output, 64, the instruction cache byte address, equal to pc.
REQ-005 The block SHALL have port imemReq, output, 1, the instruction cache request strobe.
REQ-006 The block SHALL have port imemAck, input, 1, the cache response; imemData is valid in the same cycle.
REQ-007 The block SHALL have port imemData, input, 32, the fetched instruction word.
REQ-008 The block SHALL have port instruction, output, 32, the instruction presented to the decoder/controller.
REQ-009 The block SHALL have port instrValid, output, 1, asserted while instruction holds an unconsumed word.
REQ-010 The block SHALL have port instrReady, input, 1, asserted by the decoder when it accepts instruction.
REQ-011 The block SHALL have port branchResolve, input, 1, a one-cycle strobe indicating that the branch inputs are valid.
REQ-012 The block SHALL have port unconditionalBranch, input, 1, the controller B/BL flag.
REQ-013 The block SHALL have port branch, input, 1, the controller CBZ flag.
REQ-014 The block SHALL have port zeroFlag, input, 1, the ALU zero result.
REQ-015 The block SHALL have port branchOffset, input, 64, a sign-extended word offset.
REQ-016 The block SHALL have port pc, output, 64, the current program counter.

Function
REQ-017 The FSM SHALL have four states: FETCH, WAIT, HOLD and RESOLVE.
REQ-018 FETCH: imemReq=1 for one cycle, then go to WAIT (if imemAck is already 1 that cycle, go directly to HOLD).
REQ-019 WAIT: imemReq SHALL stay 1 until imemAck; on imemAck, latch imemData into instruction, set instrValid=1 and go to HOLD.
REQ-020 Only one request SHALL be outstanding at a time; imemAck outside FETCH/WAIT SHALL be ignored.
REQ-021 HOLD: instruction and instrValid SHALL be stable until the cycle where instrValid&instrReady; then clear instrValid and go to RESOLVE.
REQ-022 RESOLVE: hold pc until branchResolve=1; pc SHALL NOT change before that.
REQ-023 taken = unconditionalBranch | (branch & zeroFlag), sampled in the branchResolve cycle.
REQ-024 On branchResolve, the next pc SHALL be taken ? pc + (branchOffset<<2) : pc + 4, and the FSM SHALL go to FETCH.
REQ-025 All pc arithmetic SHALL be modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0, and negative offsets wrap the same way.
REQ-026 branchResolve in any state other than RESOLVE SHALL be ignored.
REQ-027 imemAddr SHALL equal pc at all times; pc changes only at the RESOLVE exit.
REQ-028 Latency from the branchResolve edge to imemReq=1 SHALL be one cycle.

Reset
REQ-029 On reset assertion, at any time including mid-request, the block SHALL asynchronously set pc=RESET_PC, state=FETCH, imemReq=0, instrValid=0, instruction=0, linkAddr=0 and takenCount=0.
REQ-030 After reset deasserts, the first imemReq SHALL occur on the first rising clock edge.
REQ-031 A pending imemAck arriving after reset SHALL be discarded unless the block is in FETCH/WAIT.

Configuration
REQ-032 With macro FETCH_LINK_REG_EN defined, the block SHALL add output linkAddr[63:0], loaded with pc+4 when a taken unconditionalBranch resolves and held otherwise.
REQ-033 With FETCH_LINK_REG_EN defined, the block SHALL also add output takenCount[31:0], incremented on each taken resolve and wrapping at 2^32.
REQ-034 Without FETCH_LINK_REG_EN, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset, with the cache acking after 2 cycles with 32'h8B020020 -> imemAddr=0, instrValid=1 on the ack+1 cycle, instruction=32'h8B020020.
REQ-036 Accept, then branchResolve with all flags 0 -> pc=4, and imemReq=1 on the next cycle.
REQ-037 pc=64'h100, unconditionalBranch=1, branchOffset=-4 -> pc=64'hF0 and linkAddr=64'h104 (macro on).
REQ-038 branch=1 with zeroFlag=0 -> pc+4; with zeroFlag=1 and offset=3 -> pc+12.
REQ-039 instrReady held 0 for 5 cycles -> instruction is stable and no new imemReq is issued.
REQ-040 Reset asserted in WAIT with a late imemAck -> pc=RESET_PC, instrValid stays 0, and a fresh request is made.
